// File: rtl/fwd_cap_pkg.sv
// Shared types and helpers for the forwarding-value capture bank.
// Optional hold statistics are enabled by defining FWD_CAP_STATS_EN.
package fwd_cap_pkg;

    typedef enum logic {CAP_IDLE, CAP_HOLD} cap_state_e;

    localparam int SEL_NONE = 0;

    function automatic int sel_w(input int nsrc);
        return $clog2(nsrc + 1);
    endfunction

endpackage

// File: rtl/fwd_capture_bank_if.sv
// Operand/forwarding bundle between the forwarding unit and the capture bank.
// hold_cnt_o is only live when FWD_CAP_STATS_EN is defined.
interface fwd_capture_bank_if
    import fwd_cap_pkg::*;
#(
    parameter int W       = 32,
    parameter int NUM_OPS = 3,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 8
);
    localparam int SEL_W = sel_w(NUM_SRC);

    logic                     stall_i;
    logic                     flush_i;
    logic [NUM_SRC*W-1:0]     src_data_i;
    logic [NUM_OPS*SEL_W-1:0] fwd_sel_i;
    logic [NUM_OPS*W-1:0]     fwd_data_o;
    logic [NUM_OPS*SEL_W-1:0] fwd_sel_o;
    logic [NUM_OPS-1:0]       hold_o;
    logic [NUM_OPS*CNT_W-1:0] hold_cnt_o;

    modport master (
        output stall_i, flush_i, src_data_i, fwd_sel_i,
        input  fwd_data_o, fwd_sel_o, hold_o, hold_cnt_o
    );

    modport slave (
        input  stall_i, flush_i, src_data_i, fwd_sel_i,
        output fwd_data_o, fwd_sel_o, hold_o, hold_cnt_o
    );
endinterface

// File: rtl/fwd_cap_lane.sv
// One operand lane: source mux, IDLE/HOLD capture FSM, capture registers.
// With FWD_CAP_STATS_EN a saturating hold-cycle counter is added.
module fwd_cap_lane
    import fwd_cap_pkg::*;
#(
    parameter int W       = 32,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 8,
    parameter int SEL_W   = sel_w(NUM_SRC)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [NUM_SRC*W-1:0] src_data,
    input  logic [SEL_W-1:0]     sel_in,
    output logic [W-1:0]         data_out,
    output logic [SEL_W-1:0]     sel_out,
    output logic                 hold,
    output logic [CNT_W-1:0]     hold_cnt
);
    cap_state_e       state;
    cap_state_e       state_nxt;
    logic [W-1:0]     cap_data;
    logic [SEL_W-1:0] cap_sel;
    logic [W-1:0]     res_data;
    logic [SEL_W-1:0] res_sel;
    logic             sel_ok;

    // Resolve selector to a source value; out-of-range acts as "no forward"
    always_comb begin
        res_data = '0;
        res_sel  = SEL_W'(SEL_NONE);
        sel_ok   = (sel_in != SEL_W'(SEL_NONE)) && (int'(sel_in) <= NUM_SRC);
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel_in == SEL_W'(k + 1)) begin
                res_data = src_data[k*W +: W];
            end
        end
        if (sel_ok) begin
            res_sel = sel_in;
        end
    end

    // Next state: flush wins, otherwise enter HOLD on a stalled valid forward
    always_comb begin
        state_nxt = state;
        unique case (state)
            CAP_IDLE: if (stall && sel_ok) state_nxt = CAP_HOLD;
            CAP_HOLD: if (!stall) state_nxt = CAP_IDLE;
        endcase
        if (flush) begin
            state_nxt = CAP_IDLE;
        end
    end

    // State register; capture registers track the live value while IDLE
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= CAP_IDLE;
            cap_data <= '0;
            cap_sel  <= '0;
        end else begin
            state <= state_nxt;
            if (state == CAP_IDLE && !flush) begin
                cap_data <= res_data;
                cap_sel  <= res_sel;
            end
        end
    end

    assign hold     = (state == CAP_HOLD);
    assign data_out = hold ? cap_data : res_data;
    assign sel_out  = hold ? cap_sel  : res_sel;

`ifdef FWD_CAP_STATS_EN
    logic [CNT_W-1:0] cnt;

    // Hold-cycle counter: restart on HOLD entry, saturate, freeze in IDLE
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state == CAP_IDLE && state_nxt == CAP_HOLD) begin
            cnt <= '0;
        end else if (state == CAP_HOLD && cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign hold_cnt = cnt;
`else
    assign hold_cnt = '0;
`endif

endmodule

// File: rtl/fwd_capture_bank.sv
// EXE-stage forwarding capture bank: NUM_OPS independent capture lanes.
// Hold statistics per lane are compiled in with FWD_CAP_STATS_EN.
module fwd_capture_bank
    import fwd_cap_pkg::*;
#(
    parameter int W       = 32,
    parameter int NUM_OPS = 3,
    parameter int NUM_SRC = 2,
    parameter int FP_TYPE = 0,
    parameter int CNT_W   = 8
) (
    input logic              clk,
    input logic              reset_n,
    fwd_capture_bank_if.slave bus
);
    localparam int SEL_W = sel_w(NUM_SRC);

    // FP_TYPE only tags the instance; it must be a boolean
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (FP_TYPE == 0 || FP_TYPE == 1);
        end
    end

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_lane
        fwd_cap_lane #(
            .W       (W),
            .NUM_SRC (NUM_SRC),
            .CNT_W   (CNT_W),
            .SEL_W   (SEL_W)
        ) u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .stall    (bus.stall_i),
            .flush    (bus.flush_i),
            .src_data (bus.src_data_i),
            .sel_in   (bus.fwd_sel_i[i*SEL_W +: SEL_W]),
            .data_out (bus.fwd_data_o[i*W +: W]),
            .sel_out  (bus.fwd_sel_o[i*SEL_W +: SEL_W]),
            .hold     (bus.hold_o[i]),
            .hold_cnt (bus.hold_cnt_o[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_fwd_capture_bank.sv
// Scoreboard bench for fwd_capture_bank (3 lanes, 2 sources, CNT_W=2).
// Counter expectations apply when FWD_CAP_STATS_EN is defined, else 0.
module tb_fwd_capture_bank;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    fwd_capture_bank_if #(.W(32), .NUM_OPS(3), .NUM_SRC(2), .CNT_W(2)) bus ();

    fwd_capture_bank #(
        .W(32), .NUM_OPS(3), .NUM_SRC(2), .FP_TYPE(0), .CNT_W(2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [95:0] data;
        logic [5:0]  sel;
        logic [2:0]  hold;
        logic [5:0]  cnt;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Monitor: compare every presented cycle against the oldest expectation
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if (bus.fwd_data_o !== e.data)
                $display("FAIL %s data: got %h want %h", e.name, bus.fwd_data_o, e.data);
            else n_pass++;
            n_checks++;
            if (bus.fwd_sel_o !== e.sel)
                $display("FAIL %s sel: got %b want %b", e.name, bus.fwd_sel_o, e.sel);
            else n_pass++;
            n_checks++;
            if (bus.hold_o !== e.hold)
                $display("FAIL %s hold: got %b want %b", e.name, bus.hold_o, e.hold);
            else n_pass++;
            n_checks++;
            if (bus.hold_cnt_o !== e.cnt)
                $display("FAIL %s cnt: got %b want %b", e.name, bus.hold_cnt_o, e.cnt);
            else n_pass++;
        end
    end

    function automatic logic [5:0] sv(input int l2, input int l1, input int l0);
        return {2'(l2), 2'(l1), 2'(l0)};
    endfunction

    function automatic logic [95:0] dv(input logic [31:0] d2, d1, d0);
        return {d2, d1, d0};
    endfunction

    task automatic step(
        input logic        rst,
        input logic        stall,
        input logic        flush,
        input logic [31:0] mem,
        input logic [31:0] wb,
        input logic [5:0]  sel,
        input logic [95:0] edata,
        input logic [5:0]  esel,
        input logic [2:0]  ehold,
        input logic [5:0]  ecnt,
        input string       name
    );
        exp_t e;
        @(posedge clk);
        #1;
        reset_n        = rst;
        bus.stall_i    = stall;
        bus.flush_i    = flush;
        bus.src_data_i = {wb, mem};
        bus.fwd_sel_i  = sel;
        e.data = edata;
        e.sel  = esel;
        e.hold = ehold;
`ifdef FWD_CAP_STATS_EN
        e.cnt  = ecnt;
`else
        e.cnt  = 6'd0;
`endif
        e.name = name;
        q.push_back(e);
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.stall_i    = 1'b0;
        bus.flush_i    = 1'b0;
        bus.src_data_i = {32'h0, 32'hAAAA_5555};
        bus.fwd_sel_i  = sv(0, 0, 1);
        repeat (2) @(posedge clk);

        // reset passthrough
        step(0, 0, 0, 32'hAAAA_5555, 0, sv(0,0,1),
             dv(0, 0, 32'hAAAA_5555), sv(0,0,1), 3'b000, sv(0,0,0), "rst1");
        step(0, 0, 0, 32'hAAAA_5555, 0, sv(0,0,1),
             dv(0, 0, 32'hAAAA_5555), sv(0,0,1), 3'b000, sv(0,0,0), "rst2");
        // capture lane0 from MEM
        step(1, 1, 0, 32'h11, 0, sv(0,0,1),
             dv(0, 0, 32'h11), sv(0,0,1), 3'b000, sv(0,0,0), "cap_in");
        step(1, 1, 0, 32'h22, 0, sv(0,0,1),
             dv(0, 0, 32'h11), sv(0,0,1), 3'b001, sv(0,0,0), "cap_h1");
        step(1, 1, 0, 32'h22, 0, sv(0,0,1),
             dv(0, 0, 32'h11), sv(0,0,1), 3'b001, sv(0,0,1), "cap_h2");
        step(1, 0, 0, 32'h22, 0, sv(0,0,1),
             dv(0, 0, 32'h11), sv(0,0,1), 3'b001, sv(0,0,2), "cap_unst");
        step(1, 0, 0, 32'h22, 0, sv(0,0,1),
             dv(0, 0, 32'h22), sv(0,0,1), 3'b000, sv(0,0,3), "cap_rel");
        // lane independence
        step(1, 1, 0, 32'h0, 32'h33, sv(0,0,2),
             dv(0, 0, 32'h33), sv(0,0,2), 3'b000, sv(0,0,3), "ind_in");
        step(1, 1, 0, 32'h44, 32'h55, sv(0,1,2),
             dv(0, 32'h44, 32'h33), sv(0,1,2), 3'b001, sv(0,0,0), "ind_l1");
        step(1, 1, 0, 32'h66, 32'h77, sv(0,2,1),
             dv(0, 32'h44, 32'h33), sv(0,1,2), 3'b011, sv(0,0,1), "ind_both");
        // flush while held
        step(1, 1, 1, 32'h66, 32'h77, sv(0,2,1),
             dv(0, 32'h44, 32'h33), sv(0,1,2), 3'b011, sv(0,1,2), "fl_req");
        step(1, 1, 0, 32'h66, 32'h77, sv(0,2,1),
             dv(0, 32'h77, 32'h66), sv(0,2,1), 3'b000, sv(0,2,3), "fl_pass");
        step(1, 0, 0, 32'h88, 32'h99, sv(0,2,1),
             dv(0, 32'h77, 32'h66), sv(0,2,1), 3'b011, sv(0,0,0), "recap");
        step(1, 0, 0, 32'h88, 32'h99, sv(0,0,0),
             dv(0, 0, 0), sv(0,0,0), 3'b000, sv(0,1,1), "sel0");
        // invalid selector
        step(1, 1, 0, 32'h12, 32'h34, sv(3,0,3),
             dv(0, 0, 0), sv(0,0,0), 3'b000, sv(0,1,1), "inv1");
        step(1, 1, 0, 32'h12, 32'h34, sv(3,0,3),
             dv(0, 0, 0), sv(0,0,0), 3'b000, sv(0,1,1), "inv2");
        // long stall on lane2: counter saturation
        step(1, 1, 0, 0, 32'h5A, sv(2,0,0),
             dv(32'h5A, 0, 0), sv(2,0,0), 3'b000, sv(0,1,1), "sat_in");
        step(1, 1, 0, 0, 0, sv(2,0,0),
             dv(32'h5A, 0, 0), sv(2,0,0), 3'b100, sv(0,1,1), "sat0");
        step(1, 1, 0, 0, 0, sv(2,0,0),
             dv(32'h5A, 0, 0), sv(2,0,0), 3'b100, sv(1,1,1), "sat1");
        step(1, 1, 0, 0, 0, sv(2,0,0),
             dv(32'h5A, 0, 0), sv(2,0,0), 3'b100, sv(2,1,1), "sat2");
        step(1, 1, 0, 0, 0, sv(2,0,0),
             dv(32'h5A, 0, 0), sv(2,0,0), 3'b100, sv(3,1,1), "sat3");
        step(1, 1, 0, 0, 0, sv(2,0,0),
             dv(32'h5A, 0, 0), sv(2,0,0), 3'b100, sv(3,1,1), "sat_keep");
        step(1, 0, 0, 0, 0, sv(2,0,0),
             dv(32'h5A, 0, 0), sv(2,0,0), 3'b100, sv(3,1,1), "sat_unst");
        step(1, 0, 0, 0, 0, sv(2,0,0),
             dv(0, 0, 0), sv(2,0,0), 3'b000, sv(3,1,1), "sat_idle");
        // reset asserted mid-HOLD
        step(1, 1, 0, 0, 32'hBB, sv(2,0,0),
             dv(32'hBB, 0, 0), sv(2,0,0), 3'b000, sv(3,1,1), "mr_in");
        step(0, 1, 0, 0, 32'hCC, sv(2,0,0),
             dv(32'hBB, 0, 0), sv(2,0,0), 3'b100, sv(0,1,1), "mr_hold");
        step(1, 1, 0, 0, 32'hCC, sv(2,0,0),
             dv(32'hCC, 0, 0), sv(2,0,0), 3'b000, sv(0,0,0), "mr_idle");
        step(1, 0, 0, 0, 32'hDD, sv(0,0,0),
             dv(32'hCC, 0, 0), sv(2,0,0), 3'b100, sv(0,0,0), "mr_recap");

        for (int t = 0; t < 10 && q.size() > 0; t++) @(posedge clk);
        if (q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        #20;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
